// File: rtl/usr_pkg.sv
// usr_pkg: shared mode encoding and limits for the universal shift register.
package usr_pkg;
    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHR  = 2'b01,
        SHL  = 2'b10,
        LOAD = 2'b11
    } usr_mode_e;
    localparam int USR_MAX_WIDTH = 64;
endpackage

// File: rtl/usr_shift_counter.sv
// usr_shift_counter: counts shifts modulo WIDTH and pulses frame_done on each wrap.
module usr_shift_counter #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         inc,
    input  logic                         clr,
    output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
    output logic                         frame_done
);
    localparam int CW = $clog2(WIDTH + 1);
    logic w_wrap;
    assign w_wrap = inc && (shift_cnt == CW'(WIDTH - 1));
    // A load clears the count and suppresses the pulse even on the wrapping shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_wrap && !clr;
            shift_cnt  <= (clr || w_wrap) ? '0 : inc ? shift_cnt + 1'b1 : shift_cnt;
        end
    end
endmodule

// File: rtl/universal_shift_register.sv
// universal_shift_register: WIDTH-bit hold/shift-right/shift-left/load register
// with serial taps at both ends and a frame-complete pulse.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] par_out,
    output logic             serial_out_r,
    output logic             serial_out_l,
    output logic             frame_done
);
    usr_mode_e                    w_mode;
    logic [WIDTH-1:0]             r_q;
    logic [WIDTH-1:0]             w_q_next;
    logic                         w_inc;
    logic                         w_clr;
    logic [$clog2(WIDTH+1)-1:0]   w_shift_cnt;

    assign w_mode = usr_mode_e'(mode);
    assign w_inc  = en && (w_mode == SHR || w_mode == SHL);
    assign w_clr  = en && (w_mode == LOAD);

    always_comb begin
        w_q_next = r_q;
        case (w_mode)
            SHR:     w_q_next = {serial_in, r_q[WIDTH-1:1]};
            SHL:     w_q_next = {r_q[WIDTH-2:0], serial_in};
            LOAD:    w_q_next = par_in;
            default: w_q_next = r_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= '0;
        else if (en)
            r_q <= w_q_next;
    end

    usr_shift_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (w_inc),
        .clr        (w_clr),
        .shift_cnt  (w_shift_cnt),
        .frame_done (frame_done)
    );

    assign par_out      = r_q;
    assign serial_out_r = r_q[0];
    assign serial_out_l = r_q[WIDTH-1];
endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised universal shift register, the successor to the single-bit SISO shifter. Four operating modes (hold, shift right, shift left, parallel load) over a WIDTH-bit register, with serial ports at both ends and a parallel read-out. A shift counter pulses `frame_done` when a full WIDTH-bit word has been shifted. It is used for serial/parallel conversion between the serial front-end blocks and word-wide logic.

## Interface
- `WIDTH`, 8, register width in bits; legal range 2..64.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  clock enable; when 0, all state holds regardless of `mode`.
- `mode`  in  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `serial_in`  in  1  serial data bit, used in both shift modes.
- `par_in`  in  WIDTH  parallel load data.
- `par_out`  out  WIDTH  register contents `q`.
- `serial_out_r`  out  1  `q[0]`, the bit leaving on a right shift.
- `serial_out_l`  out  1  `q[WIDTH-1]`, the bit leaving on a left shift.
- `frame_done`  out  1  one-cycle pulse: WIDTH shifts completed since the last reset, load or frame.

## Operation
- Reset (asynchronous, `rst_n`=0): `q`=0, `shift_cnt`=0, `frame_done`=0. All outputs read 0 while in reset.
- `en`=0: `q`, `shift_cnt` and `mode` effect all frozen; `frame_done` is forced to 0 on that edge.
- Hold (00), `en`=1: `q` and `shift_cnt` unchanged; `frame_done` goes to 0.
- Shift right (01): `q <= {serial_in, q[WIDTH-1:1]}`.
- Shift left (10): `q <= {q[WIDTH-2:0], serial_in}`.
- Parallel load (11): `q <= par_in`; `shift_cnt` is cleared to 0; `frame_done` goes to 0.
- Shift counter:
  - Width `$clog2(WIDTH+1)`.
  - Increments on each enabled shift in either direction. Mixed left and right shifts both count.
  - On the shift that would take it to WIDTH, it wraps to 0 and sets `frame_done` to 1 for exactly one cycle.
- `serial_out_r` and `serial_out_l` are combinational taps of registered `q`. There is no extra output register.
- Invalid or X `mode` is not expected; the RTL treats it as hold (default branch).

## Timing
- Latency for a shift or load: 1 cycle. `par_out` reflects the result right after the edge.
- First serial bit to `serial_out_r`, with continuous right shifts: the bit appears at `serial_out_r` WIDTH cycles after it is sampled. This matches a WIDTH-stage SISO.
- `frame_done` timing:
  - Registered, high in the cycle immediately after the edge that performs the WIDTH-th shift.
  - In that cycle `par_out` holds the complete word.
  - Back-to-back frames give pulses exactly WIDTH cycles apart.
- Load on the same edge the frame would complete: the load wins, `shift_cnt`=0 and no `frame_done` pulse.
- Reset asserted mid-frame: everything clears immediately. The next frame needs WIDTH fresh shifts.
- Deassertion of `rst_n` is assumed to be synchronised externally.

## Structure
- Package `usr_pkg` contains:
  - enum `usr_mode_e` with HOLD=2'b00, SHR=2'b01, SHL=2'b10, LOAD=2'b11.
  - Constant `USR_MAX_WIDTH`=64.
- Sub-module `usr_shift_counter`:
  - Parameter WIDTH; inputs `clk`, `rst_n`, `inc`, `clr`.
  - Outputs `shift_cnt` and registered `frame_done`.
  - Owns the wrap logic and the clear-beats-increment priority.
- The top level holds the data register, the mode mux and the serial taps.

## Test plan
All scenarios use WIDTH=8.
- Reset: drive `rst_n`=0 mid-clock-period with `q`=8'hA5 → `par_out`=0, `frame_done`=0 and both serial outputs 0 immediately, before the next edge.
- Right shift: shift right 8 cycles with `serial_in` = 1,0,1,1,0,0,1,0 → `par_out`=8'h4D; `frame_done` high for one cycle only after the 8th edge; `serial_out_r` then emits 1,0,1,1,... on further shifts.
- Left shift: load 8'h81, then shift left 3 cycles with `serial_in`=1 → `par_out`=8'h0F. `serial_out_l` reads 1 before the first shift and 0 after it.
- Enable: load 8'h3C, hold `en`=0 for 5 cycles with `mode`=01 → `par_out` stays 8'h3C and `shift_cnt` is unchanged.
- Load beats frame completion: do 7 shifts, then load 8'hFF on the edge where the 8th shift would occur → `par_out`=8'hFF, no `frame_done`; 8 further shifts then produce exactly one pulse.
- Reset mid-frame: do 5 shifts, pulse `rst_n` low, then do 8 shifts → `frame_done` pulses only after the 8th post-reset shift.
